stream_rr_arbiter: RTL and testbench
====================================

// Module: stream_rr_arbiter
// PURPOSE
// - Shares one downstream ctrl/data/valid/ready stream target between NUM_MASTERS upstream stream sources.
// - Uses round-robin arbitration; the output is registered.
// - Sits between the per-master stream producers and the single shared consumer (e.g. one t2-style sink).
// - Reports which master owns each output beat and keeps a saturating count of accepted beats.
// PARAMETERS
// - NUM_MASTERS  4   number of requesting streams; 2..8.
// - CTRL_BITS    8   width of the ctrl field. ctrl[0] is the LAST flag.
// - DATA_BITS    32  width of the data field.
// - CNT_BITS     16  width of the accepted-beat counter.
// PORTS
// - clk        in   1                        single clock; all logic is on its rising edge.
// - rst        in   1                        synchronous reset, active-high.
// - in_valid   in   NUM_MASTERS              per-master valid.
// - in_ready   out  NUM_MASTERS              per-master ready; at most one bit set per cycle.
// - in_ctrl    in   NUM_MASTERS*CTRL_BITS    master i occupies bits [i*CTRL_BITS +: CTRL_BITS].
// - in_data    in   NUM_MASTERS*DATA_BITS    master i occupies bits [i*DATA_BITS +: DATA_BITS].
// - out_valid  out  1                        registered valid to the target.
// - out_ready  in   1                        target ready.
// - out_ctrl   out  CTRL_BITS                registered ctrl.
// - out_data   out  DATA_BITS                registered data.
// - out_src    out  $clog2(NUM_MASTERS)      index of the master that owns the current output beat.
// - beat_cnt   out  CNT_BITS                 accepted output beats (out_valid & out_ready); saturates at all-ones.
// BEHAVIOUR
// - Reset values:
//   - out_valid=0, in_ready=0, out_ctrl=0, out_data=0, out_src=0, beat_cnt=0.
//   - RR pointer=0; FSM in IDLE.
// - Handshake:
//   - A transfer occurs when valid & ready are both high in the same cycle.
//   - Sources must hold valid, ctrl and data stable until ready.
//   - out_* are held stable while out_valid & !out_ready.
// - Arbitration:
//   - Each cycle, grant = first i with in_valid[i], scanning from RR pointer upward, modulo NUM_MASTERS.
//   - in_ready[grant]=1 only when the output stage can accept a beat.
//   - On acceptance of a beat from master g, the RR pointer becomes (g+1) mod NUM_MASTERS.
// - Output stage:
//   - 2-entry skid buffer; latency is 1 cycle from input acceptance to out_valid.
//   - Sustains full throughput (1 beat/cycle).
//   - in_ready depends only on registered skid state, never combinationally on out_ready.
// - FSM (burst lock):
//   - IDLE: arbitrate per the rule above. An accepted beat with ctrl[0]=0 -> LOCKED(g).
//   - LOCKED(g): grant is forced to g; other masters see in_ready=0 even if g drops valid.
//   - An accepted beat from g with ctrl[0]=1 -> IDLE, and the pointer advances to g+1.
//   - A beat with ctrl[0]=1 accepted in IDLE stays in IDLE (single-beat burst).
// - Boundary cases:
//   - No valid inputs: no grant, pointer holds.
//   - Output buffer full: in_ready=0 everywhere; state holds.
//   - Simultaneous output drain and input accept: allowed in the same cycle; occupancy unchanged.
//   - beat_cnt: holds at 2^CNT_BITS-1, no wrap. The pointer wraps from NUM_MASTERS-1 to 0.
//   - Reset mid-burst: lock, buffer and counter are cleared in the cycle after rst is sampled high; buffered beats are dropped.
// CONFIGURATION
// - STREAM_ARB_LOCK_EN defined: the burst-lock FSM above is present.
// - STREAM_ARB_LOCK_EN undefined:
//   - FSM is absent; arbitration is per beat and ctrl[0] is ignored.
//   - The RR pointer advances after every accepted beat.
//   - Ports are unchanged.
// STRUCTURE
// - Package stream_arb_pkg:
//   - localparam CTRL_LAST_BIT = 0.
//   - typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_e.
//   - function rr_pick(valid, ptr) returning the grant index and a found flag.
// - Sub-module stream_skid_buf:
//   - Parameter W = CTRL_BITS+DATA_BITS+$clog2(NUM_MASTERS).
//   - Ports: clk, rst, in_valid/in_ready/in_payload, out_valid/out_ready/out_payload.
// - Top level: pick logic, FSM, pointer and counter; one stream_skid_buf instance.
// TESTING
// - Reset then idle:
//   - Assert rst for 2 cycles with all in_valid=0 -> every output is at its reset value.
//   - out_valid stays 0 for 10 cycles.
// - Fairness:
//   - All 4 masters valid with single beats (ctrl=8'h01), out_ready=1.
//   - -> out_src sequence is 0,1,2,3,0,1...; beat_cnt=8 after 8 accepts.
// - Backpressure:
//   - out_ready=0 for 5 cycles while master 2 sends data 32'hA5A5_0001..0003.
//   - -> at most 2 beats are buffered and in_ready[2]=0 once full.
//   - -> after release, data comes out in order with no loss or duplication.
// - Burst lock (STREAM_ARB_LOCK_EN):
//   - Master 1 sends a 3-beat burst (ctrl 8'h00, 8'h00, 8'h01) while master 0 is valid.
//   - -> the three out_src=1 beats are contiguous, then out_src=0.
//   - With the macro undefined, the same stimulus -> beats interleave 1,0,...
// - Saturation:
//   - Parameter CNT_BITS=4; accept 20 beats -> beat_cnt reads 4'hF and holds.
// - Reset mid-burst:
//   - Assert rst after beat 1 of a 3-beat burst from master 3.
//   - -> next cycle: out_valid=0 and the FSM is IDLE; master 0 is granted first afterwards.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared types and the round-robin pick helper for the stream arbiter.
package stream_arb_pkg;

  localparam int unsigned CTRL_LAST_BIT = 0;
  localparam int unsigned MAX_MASTERS   = 8;
  localparam int unsigned PICK_W        = 3;

  typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_e;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or above ptr, wrapping modulo n (n <= MAX_MASTERS, ptr < n).
  function automatic rr_pick_t rr_pick(input logic [MAX_MASTERS-1:0] valid,
                                       input logic [PICK_W-1:0]      ptr,
                                       input int unsigned            n);
    rr_pick_t    res;
    int unsigned i;
    res = '0;
    for (int unsigned k = 0; k < MAX_MASTERS; k++) begin
      if (k < n) begin
        i = 32'(ptr) + k;
        if (i >= n) i = i - n;
        if (!res.found && valid[PICK_W'(i)]) begin
          res.found = 1'b1;
          res.idx   = PICK_W'(i);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry registered skid buffer; in_ready comes from registered state only.
module stream_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload
);

  logic         out_valid_q, out_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;

  assign in_ready    = !skid_valid_q;
  assign accept      = in_valid && !skid_valid_q;
  assign out_valid   = out_valid_q;
  assign out_payload = out_q;

  // Output slot refills from the skid slot first, so order is preserved.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = in_payload;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = in_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered output stream among NUM_MASTERS sources.
// Define STREAM_ARB_LOCK_EN to hold the grant for a whole burst (until ctrl LAST).
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 4,
  parameter  int unsigned CTRL_BITS   = 8,
  parameter  int unsigned DATA_BITS   = 32,
  parameter  int unsigned CNT_BITS    = 16,
  localparam int unsigned SRC_W       = $clog2(NUM_MASTERS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_MASTERS-1:0]           in_valid,
  output logic [NUM_MASTERS-1:0]           in_ready,
  input  logic [NUM_MASTERS*CTRL_BITS-1:0] in_ctrl,
  input  logic [NUM_MASTERS*DATA_BITS-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CTRL_BITS-1:0]             out_ctrl,
  output logic [DATA_BITS-1:0]             out_data,
  output logic [SRC_W-1:0]                 out_src,
  output logic [CNT_BITS-1:0]              beat_cnt
);

  localparam int unsigned PAY_W = SRC_W + CTRL_BITS + DATA_BITS;

  logic [CTRL_BITS-1:0] ctrl_arr [NUM_MASTERS];
  logic [DATA_BITS-1:0] data_arr [NUM_MASTERS];
  rr_pick_t             pick;
  logic                 grant_valid;
  logic [SRC_W-1:0]     grant_idx;
  logic [CTRL_BITS-1:0] grant_ctrl;
  logic [DATA_BITS-1:0] grant_data;
  logic                 buf_ready;
  logic                 can_accept;
  logic                 accept;
  logic [SRC_W-1:0]     ptr_q, ptr_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [PAY_W-1:0]     out_payload;

  always_comb begin
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      ctrl_arr[i] = in_ctrl[i*CTRL_BITS +: CTRL_BITS];
      data_arr[i] = in_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  assign pick = rr_pick(MAX_MASTERS'(in_valid), PICK_W'(ptr_q), NUM_MASTERS);

`ifdef STREAM_ARB_LOCK_EN
  arb_state_e       state_q, state_d;
  logic [SRC_W-1:0] owner_q, owner_d;

  // A locked burst owner keeps the grant even while it has no valid beat.
  always_comb begin
    grant_valid = pick.found;
    grant_idx   = SRC_W'(pick.idx);
    if (state_q == ARB_LOCKED) begin
      grant_valid = in_valid[owner_q];
      grant_idx   = owner_q;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (accept && !grant_ctrl[CTRL_LAST_BIT]) begin
          state_d = ARB_LOCKED;
          owner_d = grant_idx;
        end
      end
      ARB_LOCKED: begin
        if (accept && grant_ctrl[CTRL_LAST_BIT]) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`else
  always_comb begin
    grant_valid = pick.found;
    grant_idx   = SRC_W'(pick.idx);
  end
`endif

  assign grant_ctrl = ctrl_arr[grant_idx];
  assign grant_data = data_arr[grant_idx];

  // Nothing is offered while reset is asserted, so no beat is silently dropped.
  assign can_accept = buf_ready && !rst;
  assign accept     = grant_valid && can_accept;

  always_comb begin
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      in_ready[i] = can_accept && grant_valid && (grant_idx == SRC_W'(i));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_idx == SRC_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
    cnt_d = cnt_q;
    if (out_valid && out_ready && (cnt_q != '1)) cnt_d = cnt_q + CNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  stream_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (accept),
    .in_ready    (buf_ready),
    .in_payload  ({grant_idx, grant_ctrl, grant_data}),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload)
  );

  assign {out_src, out_ctrl, out_data} = out_payload;
  assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomized and directed bench for stream_rr_arbiter against a queue-based reference model.
module tb_stream_rr_arbiter;

  localparam int NM   = 4;
  localparam int CB   = 8;
  localparam int DB   = 32;
  localparam int CNTB = 4;
  localparam int SW   = 2;
  localparam int BW   = SW + CB + DB;
  localparam int CMAX = (1 << CNTB) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    in_valid;
  logic [NM-1:0]    in_ready;
  logic [NM*CB-1:0] in_ctrl;
  logic [NM*DB-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CB-1:0]    out_ctrl;
  logic [DB-1:0]    out_data;
  logic [SW-1:0]    out_src;
  logic [CNTB-1:0]  beat_cnt;

  always #5 clk = ~clk;

  stream_rr_arbiter #(
    .NUM_MASTERS (NM),
    .CTRL_BITS   (CB),
    .DATA_BITS   (DB),
    .CNT_BITS    (CNTB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_src   (out_src),
    .beat_cnt  (beat_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Sources: per-master beat queues; a presented beat is held until accepted.
  logic [CB+DB-1:0] srcq [NM][$];
  bit               pres [NM];
  int unsigned      rate;
  int unsigned      ordy;

  // Reference model: buffered beats in order, RR pointer, burst owner, counter.
  logic [BW-1:0]    mq [$];
  int               m_ptr  = 0;
  int               m_lock = -1;
  int               m_cnt  = 0;
  int               drained_src [$];
  logic [DB-1:0]    drained_data [$];

  task automatic clear_sources();
    for (int i = 0; i < NM; i++) begin
      srcq[i].delete();
      pres[i] = 1'b0;
    end
  endtask

  task automatic push(input int m, input logic [CB-1:0] c, input logic [DB-1:0] d);
    srcq[m].push_back({c, d});
  endtask

  task automatic drive();
    logic [CB+DB-1:0] b;
    for (int i = 0; i < NM; i++) begin
      if (!pres[i] && srcq[i].size() > 0 && $urandom_range(99) < rate) pres[i] = 1'b1;
      b = pres[i] ? srcq[i][0] : '0;
      in_valid[i]        = pres[i];
      in_ctrl[i*CB +: CB] = b[CB+DB-1:DB];
      in_data[i*DB +: DB] = b[DB-1:0];
    end
    out_ready = ($urandom_range(99) < ordy);
  endtask

  task automatic model_step();
    int               g;
    logic [NM-1:0]    er;
    logic [BW-1:0]    b;
    logic [CB+DB-1:0] sb;
    bit               room;
    g = -1;
    if (m_lock >= 0) begin
      if (in_valid[m_lock]) g = m_lock;
    end else begin
      for (int k = 0; k < NM; k++) begin
        if (g < 0 && in_valid[(m_ptr + k) % NM]) g = (m_ptr + k) % NM;
      end
    end
    room = (mq.size() < 2);
    er = '0;
    if (!rst && room && g >= 0) er[g] = 1'b1;
    if (rst) begin
      mq.delete();
      m_ptr  = 0;
      m_lock = -1;
      m_cnt  = 0;
      return;
    end
    check_eq("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      b = mq[0];
      check_eq("out_src", 64'(out_src), 64'(b[BW-1 -: SW]));
      check_eq("out_ctrl", 64'(out_ctrl), 64'(b[CB+DB-1:DB]));
      check_eq("out_data", 64'(out_data), 64'(b[DB-1:0]));
    end
    check_eq("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
    check_eq("in_ready", 64'(in_ready), 64'(er));
    if (mq.size() > 0 && out_ready) begin
      b = mq.pop_front();
      drained_src.push_back(int'(b[BW-1 -: SW]));
      drained_data.push_back(b[DB-1:0]);
      if (m_cnt < CMAX) m_cnt++;
    end
    if (er != '0) begin
      sb = srcq[g].pop_front();
      pres[g] = 1'b0;
      mq.push_back({SW'(g), sb});
      m_ptr = (g + 1) % NM;
`ifdef STREAM_ARB_LOCK_EN
      m_lock = sb[DB] ? -1 : g;
`endif
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_sources();
    step();
    step();
    rst = 1'b0;
    drained_src.delete();
    drained_data.delete();
  endtask

  task automatic run_drains(input string tag, input int n, input int maxc);
    int c;
    c = 0;
    while (drained_src.size() < n && c < maxc) begin
      step();
      c++;
    end
    check_eq(tag, 64'(drained_src.size()), 64'(n));
  endtask

  function automatic int drained_at(input int k);
    return (k < drained_src.size()) ? drained_src[k] : -1;
  endfunction

  int exp_burst [5];
  int pending;
  int lim;

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    rate      = 100;
    ordy      = 100;
    @(posedge clk);
    #1;

    // Reset then idle
    reset_dut();
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_in_ready", 64'(in_ready), 64'(0));
    check_eq("rst_out_ctrl", 64'(out_ctrl), 64'(0));
    check_eq("rst_out_data", 64'(out_data), 64'(0));
    check_eq("rst_out_src", 64'(out_src), 64'(0));
    check_eq("rst_beat_cnt", 64'(beat_cnt), 64'(0));
    for (int i = 0; i < 10; i++) step();

    // Fairness with single beats from every master
    reset_dut();
    for (int j = 0; j < 2; j++)
      for (int m = 0; m < NM; m++) push(m, 8'h01, 32'hF000_0000 + 32'(m * 16 + j));
    run_drains("fair_done", 8, 40);
    for (int k = 0; k < 8; k++) check_eq("fair_src", 64'(drained_at(k)), 64'(k % NM));
    check_eq("fair_cnt", 64'(beat_cnt), 64'(8));

    // Backpressure on master 2
    reset_dut();
    ordy = 0;
    for (int j = 1; j <= 3; j++) push(2, 8'h01, 32'hA5A5_0000 + 32'(j));
    for (int i = 0; i < 5; i++) step();
    check_eq("bp_rdy2_full", 64'(in_ready[2]), 64'(0));
    check_eq("bp_held_valid", 64'(out_valid), 64'(1));
    ordy = 100;
    run_drains("bp_done", 3, 20);
    for (int k = 0; k < 3; k++)
      check_eq("bp_order", 64'((k < drained_data.size()) ? drained_data[k] : 32'h0),
               64'(32'hA5A5_0001 + 32'(k)));

    // Burst from master 1 competing with master 0
    reset_dut();
    push(0, 8'h01, 32'h0000_00AA);
    run_drains("burst_pre", 1, 10);
    drained_src.delete();
    drained_data.delete();
    push(1, 8'h00, 32'h1111_0001);
    push(1, 8'h00, 32'h1111_0002);
    push(1, 8'h01, 32'h1111_0003);
    push(0, 8'h01, 32'h0000_0B01);
    push(0, 8'h01, 32'h0000_0B02);
`ifdef STREAM_ARB_LOCK_EN
    exp_burst = '{1, 1, 1, 0, 0};
`else
    exp_burst = '{1, 0, 1, 0, 1};
`endif
    run_drains("burst_done", 5, 30);
    for (int k = 0; k < 5; k++) check_eq("burst_src", 64'(drained_at(k)), 64'(exp_burst[k]));

    // Counter saturation
    reset_dut();
    for (int j = 0; j < 5; j++)
      for (int m = 0; m < NM; m++) push(m, 8'h01, $urandom);
    run_drains("sat_done", 20, 100);
    for (int i = 0; i < 3; i++) step();
    check_eq("sat_cnt", 64'(beat_cnt), 64'(CMAX));

    // Reset in the middle of a burst from master 3
    reset_dut();
    push(3, 8'h00, 32'h3333_0001);
    push(3, 8'h00, 32'h3333_0002);
    push(3, 8'h01, 32'h3333_0003);
    lim = 0;
    while (srcq[3].size() > 2 && lim < 10) begin
      step();
      lim++;
    end
    check_eq("rmb_valid", 64'(out_valid), 64'(1));
    check_eq("rmb_src", 64'(out_src), 64'(3));
    rst = 1'b1;
    clear_sources();
    step();
    rst = 1'b0;
    check_eq("rmb_cleared", 64'(out_valid), 64'(0));
    drained_src.delete();
    drained_data.delete();
    push(3, 8'h01, 32'h3333_00F3);
    push(0, 8'h01, 32'h0000_00F0);
    run_drains("rmb_done", 2, 20);
    check_eq("rmb_first", 64'(drained_at(0)), 64'(0));
    check_eq("rmb_second", 64'(drained_at(1)), 64'(3));

    // Random bursts with random backpressure
    reset_dut();
    rate = 60;
    ordy = 70;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(5) == 0) begin
        int m;
        int len;
        logic [CB-1:0] cv;
        m   = int'($urandom_range(NM - 1));
        len = int'($urandom_range(4, 1));
        if (srcq[m].size() < 6) begin
          for (int j = 0; j < len; j++) begin
            cv    = CB'($urandom);
            cv[0] = (j == len - 1);
            push(m, cv, $urandom);
          end
        end
      end
      step();
    end
    rate = 100;
    ordy = 100;
    lim  = 0;
    pending = 1;
    while (pending != 0 && lim < 300) begin
      step();
      lim++;
      pending = mq.size();
      for (int m = 0; m < NM; m++) pending += srcq[m].size();
    end
    check_eq("rand_drain", 64'(pending), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
